// File: rtl/blink_monitor.sv
// blink_monitor: measures high time and period of the RGB PWM nets and
// streams one record per period. Define BLINK_MON_TIMEOUT_EN for stuck records.
module blink_monitor #(
    parameter int CNT_W          = 24,
    parameter int TIMEOUT_CYCLES = 12_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             led_red,
    input  logic             led_green,
    input  logic             led_blue,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [1:0]       meas_chan,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_stuck,
    output logic             meas_level,
    output logic [7:0]       overrun_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [2:0] w_pin;
    logic [2:0] r_s1;
    logic [2:0] r_s2;
    logic [2:0] r_s3;
    logic [2:0] w_rise;
    logic [2:0] w_fall;
    logic [2:0] w_edge;
    logic [2:0] w_tout;

    assign w_pin  = {led_blue, led_green, led_red};
    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_edge = w_rise | w_fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= w_pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

`ifdef BLINK_MON_TIMEOUT_EN
    logic [CNT_W-1:0] r_tcnt [3];

    // Counter parks at TIMEOUT_VAL so each stuck episode fires only once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_tcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_edge[i]) begin
                    r_tcnt[i] <= '0;
                end else if (r_tcnt[i] != TIMEOUT_VAL) begin
                    r_tcnt[i] <= r_tcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_tout = '0;
        for (int i = 0; i < 3; i++) begin
            w_tout[i] = !w_edge[i] &&
                        (r_tcnt[i] == TIMEOUT_VAL - CNT_W'(1));
        end
    end
`else
    assign w_tout = '0;
`endif

    state_t           r_state [3];
    logic [CNT_W-1:0] r_cnt   [3];
    logic [CNT_W-1:0] r_high  [3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
                r_high[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_cnt[i] != CNT_MAX) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
                if (w_tout[i]) begin
                    r_state[i] <= ST_IDLE;
                end else begin
                    unique case (r_state[i])
                        ST_IDLE: begin
                            if (w_rise[i]) begin
                                r_state[i] <= ST_HIGH;
                                r_cnt[i]   <= CNT_W'(1);
                            end
                        end
                        ST_HIGH: begin
                            if (w_fall[i]) begin
                                r_high[i]  <= r_cnt[i];
                                r_state[i] <= ST_LOW;
                            end
                        end
                        ST_LOW: begin
                            if (w_rise[i]) begin
                                r_state[i] <= ST_HIGH;
                                r_cnt[i]   <= CNT_W'(1);
                            end
                        end
                        default: r_state[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    logic [2:0]       w_done;
    logic [CNT_W-1:0] w_done_high   [3];
    logic [CNT_W-1:0] w_done_period [3];
    logic [2:0]       w_done_stuck;
    logic [2:0]       w_done_level;

    // Counter restarts at 1 on a rise, so its value is the cycle distance.
    always_comb begin
        w_done       = '0;
        w_done_stuck = '0;
        w_done_level = '0;
        for (int i = 0; i < 3; i++) begin
            w_done_high[i]   = r_high[i];
            w_done_period[i] = r_cnt[i];
            if (w_tout[i]) begin
                w_done[i]        = 1'b1;
                w_done_high[i]   = '0;
                w_done_period[i] = TIMEOUT_VAL;
                w_done_stuck[i]  = 1'b1;
                w_done_level[i]  = r_s2[i];
            end else if (r_state[i] == ST_LOW && w_rise[i]) begin
                w_done[i] = 1'b1;
            end
        end
    end

    logic [2:0]       r_slot_v;
    logic [CNT_W-1:0] r_slot_high   [3];
    logic [CNT_W-1:0] r_slot_period [3];
    logic [2:0]       r_slot_stuck;
    logic [2:0]       r_slot_level;

    logic             r_out_v;
    logic [1:0]       r_out_chan;
    logic [CNT_W-1:0] r_out_high;
    logic [CNT_W-1:0] r_out_period;
    logic             r_out_stuck;
    logic             r_out_level;
    logic [7:0]       r_ovr;

    logic       w_load_ok;
    logic [2:0] w_pop;
    logic [1:0] w_sel;
    logic [2:0] w_drop;
    logic [1:0] w_drop_n;
    logic [8:0] w_ovr_sum;

    always_comb begin
        w_load_ok = !r_out_v || meas_ready;
        w_pop     = '0;
        w_sel     = 2'd0;
        if (w_load_ok) begin
            if (r_slot_v[0]) begin
                w_pop[0] = 1'b1;
                w_sel    = 2'd0;
            end else if (r_slot_v[1]) begin
                w_pop[1] = 1'b1;
                w_sel    = 2'd1;
            end else if (r_slot_v[2]) begin
                w_pop[2] = 1'b1;
                w_sel    = 2'd2;
            end
        end
    end

    // A slot being drained this cycle can take a fresh record.
    assign w_drop    = w_done & r_slot_v & ~w_pop;
    assign w_drop_n  = {1'b0, w_drop[0]} + {1'b0, w_drop[1]} +
                       {1'b0, w_drop[2]};
    assign w_ovr_sum = {1'b0, r_ovr} + {7'd0, w_drop_n};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot_v     <= '0;
            r_slot_stuck <= '0;
            r_slot_level <= '0;
            for (int i = 0; i < 3; i++) begin
                r_slot_high[i]   <= '0;
                r_slot_period[i] <= '0;
            end
            r_out_v      <= 1'b0;
            r_out_chan   <= '0;
            r_out_high   <= '0;
            r_out_period <= '0;
            r_out_stuck  <= 1'b0;
            r_out_level  <= 1'b0;
            r_ovr        <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_done[i] && !w_drop[i]) begin
                    r_slot_v[i]      <= 1'b1;
                    r_slot_high[i]   <= w_done_high[i];
                    r_slot_period[i] <= w_done_period[i];
                    r_slot_stuck[i]  <= w_done_stuck[i];
                    r_slot_level[i]  <= w_done_level[i];
                end else if (w_pop[i]) begin
                    r_slot_v[i] <= 1'b0;
                end
            end
            if (w_load_ok) begin
                r_out_v <= |r_slot_v;
                if (|r_slot_v) begin
                    r_out_chan   <= w_sel;
                    r_out_high   <= r_slot_high[w_sel];
                    r_out_period <= r_slot_period[w_sel];
                    r_out_stuck  <= r_slot_stuck[w_sel];
                    r_out_level  <= r_slot_level[w_sel];
                end
            end
            r_ovr <= w_ovr_sum[8] ? 8'hFF : w_ovr_sum[7:0];
        end
    end

    assign meas_valid  = r_out_v;
    assign meas_chan   = r_out_chan;
    assign meas_high   = r_out_high;
    assign meas_period = r_out_period;
    assign meas_stuck  = r_out_stuck;
    assign meas_level  = r_out_level;
    assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: directed checks of blink_monitor records, handshake,
// overrun, reset and timeout behaviour (CNT_W=16, TIMEOUT_CYCLES=1000).
module tb_blink_monitor;
    localparam int CW = 16;
    localparam int TO = 1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    pins;
    logic          meas_ready;
    logic          meas_valid;
    logic [1:0]    meas_chan;
    logic [CW-1:0] meas_high;
    logic [CW-1:0] meas_period;
    logic          meas_stuck;
    logic          meas_level;
    logic [7:0]    overrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit saw_stuck;

    typedef struct {
        int chan;
        int high;
        int period;
        int stuck;
        int level;
        int cyc;
    } rec_t;
    rec_t q[$];

    typedef struct {
        int ch;
        int hi;
        int lo;
        int exp_high;
        int exp_period;
    } vec_t;
    vec_t vecs[5];

    blink_monitor #(
        .CNT_W(CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .led_red(pins[0]),
        .led_green(pins[1]),
        .led_blue(pins[2]),
        .meas_valid(meas_valid),
        .meas_ready(meas_ready),
        .meas_chan(meas_chan),
        .meas_high(meas_high),
        .meas_period(meas_period),
        .meas_stuck(meas_stuck),
        .meas_level(meas_level),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && meas_valid && meas_ready)
            q.push_back('{int'(meas_chan), int'(meas_high),
                          int'(meas_period), int'(meas_stuck),
                          int'(meas_level), cyc});
        if (rst_n && meas_stuck) saw_stuck = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        pins       = '0;
        meas_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        q.delete();
        saw_stuck = 1'b0;
    endtask

    initial begin
        int t2;
        int nb;
        int nr;
        int bi;

        vecs[0] = '{0, 10, 30, 10, 40};
        vecs[1] = '{1,  3,  5,  3,  8};
        vecs[2] = '{2,  1,  1,  1,  2};
        vecs[3] = '{0,  1,  6,  1,  7};
        vecs[4] = '{1,  7,  1,  7,  8};

        do_reset();
        chk("rst_valid",  int'(meas_valid),  0);
        chk("rst_chan",   int'(meas_chan),   0);
        chk("rst_high",   int'(meas_high),   0);
        chk("rst_period", int'(meas_period), 0);
        chk("rst_stuck",  int'(meas_stuck),  0);
        chk("rst_level",  int'(meas_level),  0);
        chk("rst_ovr",    int'(overrun_cnt), 0);

        // single-channel vectors: two records each, latency and spacing
        foreach (vecs[v]) begin
            do_reset();
            meas_ready = 1'b1;
            tick(3);
            t2 = 0;
            for (int p = 0; p < 3; p++) begin
                if (p == 1) t2 = cyc;
                pins[vecs[v].ch] = 1'b1;
                tick(vecs[v].hi);
                pins[vecs[v].ch] = 1'b0;
                tick(vecs[v].lo);
            end
            tick(8);
            chk($sformatf("v%0d_count", v), q.size(), 2);
            if (q.size() >= 2) begin
                chk($sformatf("v%0d_chan", v), q[0].chan, vecs[v].ch);
                chk($sformatf("v%0d_high", v), q[0].high, vecs[v].exp_high);
                chk($sformatf("v%0d_period", v), q[0].period,
                    vecs[v].exp_period);
                chk($sformatf("v%0d_stuck", v), q[0].stuck, 0);
                chk($sformatf("v%0d_latency", v), q[0].cyc, t2 + 4);
                chk($sformatf("v%0d_spacing", v), q[1].cyc - q[0].cyc,
                    vecs[v].exp_period);
            end
        end

        // all three channels rising together
        do_reset();
        meas_ready = 1'b1;
        tick(3);
        t2 = 0;
        for (int p = 0; p < 3; p++) begin
            if (p == 1) t2 = cyc;
            pins = 3'b111;
            tick(10);
            pins = 3'b000;
            tick(10);
        end
        tick(8);
        chk("all_count", q.size(), 6);
        if (q.size() >= 6) begin
            chk("all_ch0", q[0].chan, 0);
            chk("all_ch1", q[1].chan, 1);
            chk("all_ch2", q[2].chan, 2);
            chk("all_lat", q[0].cyc, t2 + 4);
            chk("all_gap1", q[1].cyc - q[0].cyc, 1);
            chk("all_gap2", q[2].cyc - q[0].cyc, 2);
            chk("all_next", q[3].cyc - q[0].cyc, 20);
            chk("all_ch1_high", q[4].high, 10);
            chk("all_ch1_period", q[4].period, 20);
        end
        chk("all_ovr", int'(overrun_cnt), 0);

        // green with consumer stalled: hold, one slot, two drops
        do_reset();
        tick(3);
        for (int p = 0; p < 5; p++) begin
            pins[1] = 1'b1;
            tick(4);
            pins[1] = 1'b0;
            tick(4);
            if (p == 2) begin
                chk("g_mid_valid", int'(meas_valid), 1);
                chk("g_mid_chan", int'(meas_chan), 1);
            end
        end
        tick(4);
        chk("g_hold_valid",  int'(meas_valid),  1);
        chk("g_hold_chan",   int'(meas_chan),   1);
        chk("g_hold_high",   int'(meas_high),   4);
        chk("g_hold_period", int'(meas_period), 8);
        chk("g_ovr",         int'(overrun_cnt), 2);
        meas_ready = 1'b1;
        tick(10);
        chk("g_drain_count", q.size(), 2);
        if (q.size() >= 2) begin
            chk("g_drain_high",   q[0].high,   4);
            chk("g_drain_period", q[1].period, 8);
            chk("g_drain_gap",    q[1].cyc - q[0].cyc, 1);
        end
        chk("g_drain_valid", int'(meas_valid), 0);
        chk("g_drain_ovr",   int'(overrun_cnt), 2);

        // reset mid-operation with records pending
        do_reset();
        tick(3);
        for (int p = 0; p < 4; p++) begin
            pins[0] = 1'b1;
            tick(4);
            pins[0] = 1'b0;
            tick(4);
        end
        pins[0] = 1'b1;
        tick(2);
        chk("r_pre_valid", int'(meas_valid), 1);
        chk("r_pre_ovr",   int'(overrun_cnt), 1);
        rst_n = 1'b0;
        tick(1);
        chk("r_valid", int'(meas_valid), 0);
        chk("r_ovr",   int'(overrun_cnt), 0);
        pins[0] = 1'b0;
        tick(1);
        rst_n      = 1'b1;
        meas_ready = 1'b1;
        q.delete();
        tick(6);
        pins[0] = 1'b1;
        tick(4);
        pins[0] = 1'b0;
        tick(4);
        t2 = cyc;
        pins[0] = 1'b1;
        tick(3);
        chk("r_none_before", q.size(), 0);
        tick(1);
        pins[0] = 1'b0;
        tick(10);
        chk("r_count", q.size(), 1);
        if (q.size() >= 1) begin
            chk("r_lat",    q[0].cyc, t2 + 4);
            chk("r_high",   q[0].high, 4);
            chk("r_period", q[0].period, 8);
        end

        // blue stuck high past the timeout
        do_reset();
        meas_ready = 1'b1;
        tick(3);
        pins[2] = 1'b1;
        tick(1500);
        pins[2] = 1'b0;
        tick(10);
        nb = 0;
        nr = 0;
        bi = -1;
        foreach (q[i]) begin
            if (q[i].chan == 2) begin
                nb++;
                bi = i;
            end
            if (q[i].chan == 0) nr++;
        end
`ifdef BLINK_MON_TIMEOUT_EN
        chk("t_blue_count", nb, 1);
        chk("t_red_count",  nr, 1);
        if (bi >= 0) begin
            chk("t_stuck",  q[bi].stuck,  1);
            chk("t_level",  q[bi].level,  1);
            chk("t_high",   q[bi].high,   0);
            chk("t_period", q[bi].period, TO);
        end
`else
        chk("t_blue_count", nb, 0);
        chk("t_red_count",  nr, 0);
        chk("t_no_records", q.size(), 0);
        chk("t_no_stuck",   int'(saw_stuck), 0);
        chk("t_stuck_out",  int'(meas_stuck), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
